// File: rtl/disp_pkg.sv
// Shared constants and helpers for the date/time seven-segment scanner.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied
// only when the top level loads its pin registers.
package disp_pkg;

  // Slot indices, leftmost digit first
  localparam logic [1:0] SLOT_L  = 2'd3;
  localparam logic [1:0] SLOT_ML = 2'd2;
  localparam logic [1:0] SLOT_MR = 2'd1;
  localparam logic [1:0] SLOT_R  = 2'd0;

  // Active-high segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Convert an active-high segment vector to pin polarity
  function automatic logic [6:0] pol_seg(input logic [6:0] v, input logic act_low);
    return act_low ? ~v : v;
  endfunction

  // Convert an active-high anode vector to pin polarity
  function automatic logic [3:0] pol_an(input logic [3:0] v, input logic act_low);
    return act_low ? ~v : v;
  endfunction

  // Convert an active-high single pin to pin polarity
  function automatic logic pol_bit(input logic v, input logic act_low);
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-high seven-segment pattern.
// Non-decimal codes render as a dash so corrupt counter values stay visible.
module bcd_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/date_display_scan.sv
// Four-digit multiplexed seven-segment scanner for the date (MM.DD) and
// time (HH:MM) digit buses. Digits are captured once per frame so a frame
// never mixes old and new values. Pin registers are loaded from the
// next-state values, so the pins always describe the current slot/prescaler
// position with no extra cycle of lag.
module date_display_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 64,
  parameter int BLINK_SLOTS = 250,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       disp_sel,
  input  logic [3:0] d_mm1,
  input  logic [3:0] d_mm2,
  input  logic [3:0] d_dd1,
  input  logic [3:0] d_dd2,
  input  logic [3:0] t_hh1,
  input  logic [3:0] t_hh2,
  input  logic [3:0] t_mi1,
  input  logic [3:0] t_mi2,
  input  logic [3:0] blink_en,
  input  logic       lz_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_V    = CW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);
  localparam logic          AL         = (ACTIVE_LOW != 0);

  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]    slot_r, slot_nxt_s;
  logic [BW-1:0] bcnt_r, bcnt_nxt_s;
  logic          phase_r, phase_nxt_s;
  logic [15:0]   latch_r, latch_nxt_s;
  logic          mode_r, mode_nxt_s;
  logic          wrap_s;

  logic [3:0]    digit_s;
  logic [6:0]    pat_s;
  logic          guard_s;
  logic          blank_s;
  logic [3:0]    an_h_s;
  logic [6:0]    seg_h_s;
  logic          dp_h_s;

  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  // Next-state for prescaler, slot index, blink phase and frame latch
  always_comb begin
    wrap_s      = (cnt_r == CNT_MAX);
    cnt_nxt_s   = cnt_r;
    slot_nxt_s  = slot_r;
    bcnt_nxt_s  = bcnt_r;
    phase_nxt_s = phase_r;
    latch_nxt_s = latch_r;
    mode_nxt_s  = mode_r;
    if (wrap_s) begin
      cnt_nxt_s  = '0;
      // 2-bit decrement wraps 0 back to 3
      slot_nxt_s = slot_r - 2'd1;
      if (slot_r == SLOT_R) begin
        // Start of a new frame: capture the whole selected source at once
        latch_nxt_s = disp_sel ? {t_hh1, t_hh2, t_mi1, t_mi2}
                               : {d_mm1, d_mm2, d_dd1, d_dd2};
        mode_nxt_s  = disp_sel;
      end else begin
        latch_nxt_s = latch_r;
        mode_nxt_s  = mode_r;
      end
      if (slot_r == SLOT_L) begin
        // Blink cadence advances once per leftmost-slot completion
        if (bcnt_r == BLINK_LAST) begin
          bcnt_nxt_s  = '0;
          phase_nxt_s = ~phase_r;
        end else begin
          bcnt_nxt_s  = bcnt_r + BW'(1);
          phase_nxt_s = phase_r;
        end
      end else begin
        bcnt_nxt_s  = bcnt_r;
        phase_nxt_s = phase_r;
      end
    end else begin
      cnt_nxt_s  = cnt_r + CW'(1);
      slot_nxt_s = slot_r;
    end
  end

  // Select the latched digit belonging to the upcoming slot
  always_comb begin
    digit_s = 4'h0;
    case (slot_nxt_s)
      SLOT_L:  digit_s = latch_nxt_s[15:12];
      SLOT_ML: digit_s = latch_nxt_s[11:8];
      SLOT_MR: digit_s = latch_nxt_s[7:4];
      SLOT_R:  digit_s = latch_nxt_s[3:0];
      default: digit_s = 4'h0;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit_s),
    .seg (pat_s)
  );

  // Active-high pin values: guard first, then blanking, then normal drive
  always_comb begin
    guard_s = (cnt_nxt_s < GUARD_V);
    blank_s = (phase_nxt_s && blink_en[slot_nxt_s]) ||
              ((slot_nxt_s == SLOT_L) && lz_blank && (digit_s == 4'd0));
    an_h_s  = 4'b0000;
    seg_h_s = SEG_OFF;
    dp_h_s  = 1'b0;
    if (guard_s) begin
      an_h_s  = 4'b0000;
      seg_h_s = SEG_OFF;
      dp_h_s  = 1'b0;
    end else begin
      an_h_s  = 4'b0001 << slot_nxt_s;
      seg_h_s = blank_s ? SEG_OFF : pat_s;
      // Date: fixed point after MM; time: colon flashes against blink phase
      dp_h_s  = (slot_nxt_s == SLOT_ML) && (!mode_nxt_s || !phase_nxt_s);
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      slot_r  <= SLOT_L;
      bcnt_r  <= '0;
      phase_r <= 1'b0;
      latch_r <= 16'h0000;
      mode_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      slot_r  <= slot_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
      phase_r <= phase_nxt_s;
      latch_r <= latch_nxt_s;
      mode_r  <= mode_nxt_s;
    end
  end

  // Pin registers with polarity applied; reset forces every pin inactive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= pol_an(4'b0000, AL);
      seg_r <= pol_seg(SEG_OFF, AL);
      dp_r  <= pol_bit(1'b0, AL);
    end else begin
      an_r  <= pol_an(an_h_s, AL);
      seg_r <= pol_seg(seg_h_s, AL);
      dp_r  <= pol_bit(dp_h_s, AL);
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule
